// File: rtl/multi_debouncer.sv
// N-channel debouncer: synchroniser, stability counter, registered level and rise/fall pulses per channel.
// Optional sticky rise flags are built only when MULTI_DEBOUNCER_IRQ_EN is defined.
module multi_debouncer #(
    parameter int N_CH          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] sig,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] irq_pending,
    input  logic [N_CH-1:0] irq_clr
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser chain stored stage-major: sync_q[s][ch].
    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync_d [SYNC_STAGES];
    logic [N_CH-1:0]  sync_val;

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;

    always_comb begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_d[s] = (s == 0) ? sig : sync_q[(s == 0) ? 0 : s - 1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // A new value is accepted on the edge where it has been seen STABLE_CYCLES times in a row.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (!ch_en[ch]) begin
                cnt_d[ch] = '0;
            end else if (sync_val[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                cnt_d[ch]   = '0;
                level_d[ch] = sync_val[ch];
                rise_d[ch]  = sync_val[ch];
                fall_d[ch]  = ~sync_val[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

`ifdef MULTI_DEBOUNCER_IRQ_EN
    logic [N_CH-1:0] irq_q, irq_d;

    // Set on the visible rise pulse; a coinciding clear loses to the set.
    always_comb begin
        irq_d = (irq_q & ~irq_clr) | rise_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_pending = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = ^irq_clr;
    assign irq_pending    = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with default parameters (4 channels, 2 sync stages, 4 stable cycles).
// Expected irq_pending values depend on whether MULTI_DEBOUNCER_IRQ_EN is defined for the build.
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sig = 4'h0;
    logic [3:0] ch_en = 4'hF;
    logic [3:0] irq_clr = 4'h0;
    logic [3:0] level, rise, fall, irq_pending;

`ifdef MULTI_DEBOUNCER_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multi_debouncer #(
        .N_CH(4),
        .SYNC_STAGES(2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sig(sig),
        .ch_en(ch_en),
        .level(level),
        .rise(rise),
        .fall(fall),
        .irq_pending(irq_pending),
        .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] seen;

    initial begin
        // Reset held with all inputs high.
        reset_n = 1'b0;
        sig     = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_level", level, 4'h0);
            check("rst_rise", rise, 4'h0);
            check("rst_fall", fall, 4'h0);
            check("rst_irq", irq_pending, 4'h0);
        end
        reset_n = 1'b1;
        sig     = 4'h0;
        tick(6);
        check("idle_level", level, 4'h0);

        // Channel 0 rise: 5 edges after edge k, then pulse clears.
        sig[0] = 1'b1;
        tick(5);
        check("t2_early_level", level, 4'h0);
        tick(1);
        check("t2_level", level, 4'h1);
        check("t2_rise", rise, 4'h1);
        check("t2_fall", fall, 4'h0);
        irq_clr[0] = 1'b1;
        tick(1);
        check("t2_rise_clear", rise, 4'h0);
        check("t2_level_hold", level, 4'h1);
        check("t6_irq_set_wins", irq_pending, IRQ ? 4'h1 : 4'h0);
        tick(1);
        check("t6_irq_cleared", irq_pending, 4'h0);
        irq_clr[0] = 1'b0;

        // Channel 1 glitch of 3 cycles is rejected.
        seen   = 4'h0;
        sig[1] = 1'b1;
        tick(3);
        sig[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | rise | fall;
        end
        check("t3_no_pulse", seen, 4'h0);
        check("t3_level", level, 4'h1);

        // Channel 2 goes high, then drops: single fall pulse.
        sig[2] = 1'b1;
        tick(8);
        check("t4_high_level", level, 4'h5);
        check("t4_irq_ch2", irq_pending, IRQ ? 4'h4 : 4'h0);
        irq_clr = 4'h4;
        tick(1);
        irq_clr = 4'h0;
        check("t4_irq_cleared", irq_pending, 4'h0);
        sig[2] = 1'b0;
        tick(5);
        check("t4_early_level", level, 4'h5);
        check("t4_early_fall", fall, 4'h0);
        tick(1);
        check("t4_fall", fall, 4'h4);
        check("t4_rise", rise, 4'h0);
        check("t4_level", level, 4'h1);
        tick(1);
        check("t4_fall_clear", fall, 4'h0);

        // Channel 3 disabled: level frozen; re-enable restarts count.
        ch_en[3] = 1'b0;
        sig[3]   = 1'b1;
        seen     = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | rise | fall;
        end
        check("t5_dis_level", level, 4'h1);
        check("t5_dis_pulse", seen, 4'h0);
        ch_en[3] = 1'b1;
        tick(3);
        check("t5_early_level", level, 4'h1);
        tick(1);
        check("t5_rise", rise, 4'h8);
        check("t5_level", level, 4'h9);

        // Channel 1 excursion of exactly 4 cycles is accepted, then returns.
        tick(2);
        sig[1] = 1'b1;
        tick(4);
        sig[1] = 1'b0;
        tick(2);
        check("b4_rise", rise, 4'h2);
        check("b4_level", level, 4'hB);
        tick(3);
        check("b4_hold_level", level, 4'hB);
        tick(1);
        check("b4_fall", fall, 4'h2);
        check("b4_level_back", level, 4'h9);

        // Simultaneous falls on channels 0 and 3.
        tick(2);
        sig = 4'h0;
        tick(5);
        check("sim_early", level, 4'h9);
        tick(1);
        check("sim_fall", fall, 4'h9);
        check("sim_level", level, 4'h0);

        // Reset during a count discards it; counting restarts from an empty sync chain.
        tick(2);
        sig = 4'hF;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        check("mid_rst_level", level, 4'h0);
        check("mid_rst_rise", rise, 4'h0);
        reset_n = 1'b1;
        tick(5);
        check("post_rst_early", level, 4'h0);
        tick(1);
        check("post_rst_level", level, 4'hF);
        check("post_rst_rise", rise, 4'hF);
        tick(1);
        check("post_rst_irq", irq_pending, IRQ ? 4'hF : 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
